// File: rtl/rs_bank_pkg.sv
// Shared system definitions: register tags, FU types and the reservation-station packet.
package rs_bank_pkg;

    localparam int PREG_W    = 6;
    localparam int PAYLOAD_W = 32;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MULT = 2'd1,
        FU_LSU  = 2'd2,
        FU_BR   = 2'd3
    } fu_e;

    localparam int FU_COUNT = 4;

    typedef struct packed {
        logic [PREG_W-1:0] num;
        logic              ready;
    } reg_t;

    typedef struct packed {
        fu_e                  fu;
        reg_t                 tag1;
        reg_t                 tag2;
        logic [PAYLOAD_W-1:0] payload;
    } rs_packet_t;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-first selector: grants the eligible slot that no other eligible slot is older than.
module rs_age_select #(
    parameter int N = 8,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]        i_elig,
    input  logic [N-1:0][N-1:0] i_older,
    output logic [N-1:0]        o_grant,
    output logic [IW-1:0]       o_index
);

    logic [N-1:0] w_blocked;

    always_comb begin
        w_blocked = '0;
        o_grant   = '0;
        o_index   = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (i_elig[j] && i_older[j][i])
                    w_blocked[i] = 1'b1;
            end
            o_grant[i] = i_elig[i] & ~w_blocked[i];
        end
        // Valid slots are totally ordered, so the grant is one-hot and OR-encoding is exact.
        for (int i = 0; i < N; i++) begin
            if (o_grant[i])
                o_index = o_index | IW'(i);
        end
    end

endmodule

// File: rtl/rs_bank.sv
// Unified reservation station: shared slots, CDB wakeup with allocation bypass,
// oldest-ready-first issue filtered by FU availability, and flush.
module rs_bank
    import rs_bank_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_CDB     = 2,
    localparam int IDX_W = $clog2(NUM_ENTRIES),
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 alloc_valid,
    input  rs_packet_t           alloc_packet,
    output logic                 alloc_ready,
    input  logic [NUM_CDB-1:0]   cdb_valid,
    input  reg_t [NUM_CDB-1:0]   cdb_tag,
    input  logic [FU_COUNT-1:0]  fu_avail,
    output logic                 issue_valid,
    output rs_packet_t           issue_packet,
    output logic [IDX_W-1:0]     issue_index,
    input  logic                 issue_ready,
    input  logic                 flush,
    output logic [CNT_W-1:0]     free_count,
    output logic                 empty
);

    logic [NUM_ENTRIES-1:0]                  r_valid;
    rs_packet_t                              r_pkt [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] r_older;

    logic [NUM_ENTRIES-1:0] w_free;
    logic [IDX_W-1:0]       w_alloc_idx;
    logic [NUM_ENTRIES-1:0] w_wake1;
    logic [NUM_ENTRIES-1:0] w_wake2;
    logic [NUM_ENTRIES-1:0] w_elig;
    logic [NUM_ENTRIES-1:0] w_grant;
    logic [IDX_W-1:0]       w_sel_idx;
    rs_packet_t             w_alloc_pkt;
    logic                   w_alloc;
    logic                   w_fire;
    logic                   w_unused_cdb_ready;

    function automatic logic cdb_hit(input logic [NUM_CDB-1:0] v,
                                     input reg_t [NUM_CDB-1:0] t,
                                     input logic [PREG_W-1:0]  num);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (v[k] && (t[k].num == num))
                hit = 1'b1;
        end
        return hit;
    endfunction

    // Broadcast ready bits carry no meaning here; only the register number is matched.
    always_comb begin
        w_unused_cdb_ready = 1'b0;
        for (int k = 0; k < NUM_CDB; k++)
            w_unused_cdb_ready = w_unused_cdb_ready ^ cdb_tag[k].ready;
    end

    always_comb begin
        w_free      = ~r_valid;
        w_alloc_idx = '0;
        free_count  = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (w_free[i])
                w_alloc_idx = IDX_W'(i);
        end
        for (int i = 0; i < NUM_ENTRIES; i++)
            free_count = free_count + CNT_W'(w_free[i]);
    end

    assign alloc_ready = |w_free;
    assign empty       = (free_count == CNT_W'(NUM_ENTRIES));
    assign w_alloc     = alloc_valid & alloc_ready;

    always_comb begin
        w_alloc_pkt            = alloc_packet;
        w_alloc_pkt.tag1.ready = alloc_packet.tag1.ready
                               | cdb_hit(cdb_valid, cdb_tag, alloc_packet.tag1.num);
        w_alloc_pkt.tag2.ready = alloc_packet.tag2.ready
                               | cdb_hit(cdb_valid, cdb_tag, alloc_packet.tag2.num);
    end

    always_comb begin
        w_wake1 = '0;
        w_wake2 = '0;
        w_elig  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_wake1[i] = cdb_hit(cdb_valid, cdb_tag, r_pkt[i].tag1.num);
            w_wake2[i] = cdb_hit(cdb_valid, cdb_tag, r_pkt[i].tag2.num);
            w_elig[i]  = r_valid[i] & r_pkt[i].tag1.ready & r_pkt[i].tag2.ready
                       & fu_avail[r_pkt[i].fu];
        end
    end

    rs_age_select #(.N(NUM_ENTRIES)) u_age_select (
        .i_elig  (w_elig),
        .i_older (r_older),
        .o_grant (w_grant),
        .o_index (w_sel_idx)
    );

    assign issue_valid  = (|w_grant) & ~flush;
    assign issue_index  = w_sel_idx;
    assign issue_packet = r_pkt[w_sel_idx];
    assign w_fire       = issue_valid & issue_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_older <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++)
                r_pkt[i] <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (r_valid[i]) begin
                    if (w_wake1[i])
                        r_pkt[i].tag1.ready <= 1'b1;
                    if (w_wake2[i])
                        r_pkt[i].tag2.ready <= 1'b1;
                end
            end
            if (w_fire)
                r_valid[w_sel_idx] <= 1'b0;
            // New slot is younger than every slot valid before this edge; stale bits of
            // invalid slots are masked by eligibility and rewritten on their next allocation.
            if (w_alloc) begin
                r_valid[w_alloc_idx] <= 1'b1;
                r_pkt[w_alloc_idx]   <= w_alloc_pkt;
                r_older[w_alloc_idx] <= '0;
                for (int j = 0; j < NUM_ENTRIES; j++)
                    r_older[j][w_alloc_idx] <= r_valid[j];
            end
        end
    end

endmodule
